reorder_buffer: RTL and testbench

Eight-entry in-order retirement buffer for the Tomasulo core. It sits downstream of the issue stage: it accepts each dispatched instruction into the slot the issue stage names, captures results broadcast on the common data bus (CDB), and retires entries strictly in program order to the register file or memory. It drives back the per-entry busy flags that the issue stage uses for its structural-hazard check.

---
 rtl/reorder_buffer.sv | 97 +++++++++
 tb/tb_reorder_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: eight-entry in-order retirement buffer with CDB capture and per-entry busy flags
module reorder_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              issue_valid,
    input  logic [2:0]        issue_idx,
    input  logic [2:0]        issue_op,
    input  logic [REG_W-1:0]  issue_dest,
    input  logic              cdb_valid,
    input  logic [2:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [DATA_W-1:0] cdb_addr,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic [2:0]        commit_idx,
    output logic [2:0]        commit_op,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_value,
    output logic [DATA_W-1:0] commit_addr,
    output logic              busy_rb0,
    output logic              busy_rb1,
    output logic              busy_rb2,
    output logic              busy_rb3,
    output logic              busy_rb4,
    output logic              busy_rb5,
    output logic              busy_rb6,
    output logic              busy_rb7,
    output logic              rob_full,
    output logic              rob_empty,
    output logic              issue_err,
    output logic [31:0]       commit_count
);
    logic [7:0]        busy, ready;
    logic [2:0]        op    [8];
    logic [REG_W-1:0]  dest  [8];
    logic [DATA_W-1:0] value [8];
    logic [DATA_W-1:0] addr  [8];
    logic [2:0]        head;
    logic              fire, do_issue;

    assign commit_valid = busy[head] && ready[head];
    assign commit_idx   = head;
    assign commit_op    = op[head];
    assign commit_dest  = dest[head];
    assign commit_value = value[head];
    assign commit_addr  = addr[head];
    assign fire         = commit_valid && commit_ready;
    assign do_issue     = issue_valid && !busy[issue_idx];
    assign {busy_rb7, busy_rb6, busy_rb5, busy_rb4, busy_rb3, busy_rb2, busy_rb1, busy_rb0} = busy;
    assign rob_full     = &busy;
    assign rob_empty    = ~|busy;

    always_ff @(posedge clk) begin
        if (rst || !start) begin
            busy         <= '0;
            ready        <= '0;
            head         <= '0;
            commit_count <= '0;
            issue_err    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                op[i]    <= '0;
                dest[i]  <= '0;
                value[i] <= '0;
                addr[i]  <= '0;
            end
        end else begin
            issue_err <= issue_valid && busy[issue_idx];
            if (fire) begin
                head         <= head + 3'd1;
                commit_count <= commit_count + 32'd1;
            end
            // issue needs a free entry and commit a busy one, so they never hit the same slot
            for (int i = 0; i < 8; i++) begin
                if (fire && head == 3'(i)) begin
                    busy[i]  <= 1'b0;
                    ready[i] <= 1'b0;
                end
                if (do_issue && issue_idx == 3'(i)) begin
                    busy[i]  <= 1'b1;
                    ready[i] <= 1'b0;
                    op[i]    <= issue_op;
                    dest[i]  <= issue_dest;
                    value[i] <= '0;
                    addr[i]  <= '0;
                end else if (cdb_valid && cdb_tag == 3'(i) && busy[i] && !ready[i]) begin
                    value[i] <= cdb_value;
                    addr[i]  <= cdb_addr;
                    ready[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of issue, CDB capture, in-order commit, wrap and clear
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst, start, issue_valid, cdb_valid, commit_ready;
    logic [2:0]  issue_idx, issue_op, cdb_tag;
    logic [4:0]  issue_dest;
    logic [31:0] cdb_value, cdb_addr;
    logic        commit_valid, rob_full, rob_empty, issue_err;
    logic [2:0]  commit_idx, commit_op;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value, commit_addr, commit_count;
    logic        busy_rb0, busy_rb1, busy_rb2, busy_rb3, busy_rb4, busy_rb5, busy_rb6, busy_rb7;
    logic [7:0]  bv;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    assign bv = {busy_rb7, busy_rb6, busy_rb5, busy_rb4, busy_rb3, busy_rb2, busy_rb1, busy_rb0};

    reorder_buffer #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_op(issue_op), .issue_dest(issue_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_addr(cdb_addr),
        .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_idx(commit_idx),
        .commit_op(commit_op), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_addr(commit_addr),
        .busy_rb0(busy_rb0), .busy_rb1(busy_rb1), .busy_rb2(busy_rb2), .busy_rb3(busy_rb3),
        .busy_rb4(busy_rb4), .busy_rb5(busy_rb5), .busy_rb6(busy_rb6), .busy_rb7(busy_rb7),
        .rob_full(rob_full), .rob_empty(rob_empty), .issue_err(issue_err), .commit_count(commit_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] idx, input logic [2:0] op, input logic [4:0] d);
        issue_valid = 1'b1;
        issue_idx   = idx;
        issue_op    = op;
        issue_dest  = d;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] v, input logic [31:0] a);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = v;
        cdb_addr  = a;
    endtask

    task automatic quiet();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
    endtask

    initial begin
        logic [2:0] e;
        rst = 1'b1; start = 1'b1; commit_ready = 1'b0;
        issue_idx = '0; issue_op = '0; issue_dest = '0;
        cdb_tag = '0; cdb_value = '0; cdb_addr = '0;
        quiet();
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(bv), 32'h00);
        chk("rst_empty", 32'(rob_empty), 32'd1);
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_cv", 32'(commit_valid), 32'd0);
        chk("rst_cnt", commit_count, 32'd0);
        chk("rst_err", 32'(issue_err), 32'd0);
        chk("rst_head", 32'(commit_idx), 32'd0);

        // single ADD: issue, writeback, commit
        issue(3'd0, 3'd0, 5'd3); step();
        chk("t1_busy", 32'(bv), 32'h01);
        chk("t1_cv_early", 32'(commit_valid), 32'd0);
        quiet(); cdb(3'd0, 32'h15, 32'h0); step(); quiet();
        chk("t1_cv", 32'(commit_valid), 32'd1);
        chk("t1_dest", 32'(commit_dest), 32'd3);
        chk("t1_val", commit_value, 32'h15);
        commit_ready = 1'b1; step(); commit_ready = 1'b0;
        chk("t1_busy_after", 32'(bv), 32'h00);
        chk("t1_cnt", commit_count, 32'd1);
        chk("t1_head", 32'(commit_idx), 32'd1);

        // out-of-order writeback, in-order commit (head now 1)
        issue(3'd1, 3'd0, 5'd1); step();
        issue(3'd2, 3'd1, 5'd2); step();
        issue(3'd3, 3'd2, 5'd3); step();
        quiet(); cdb(3'd3, 32'h33, 32'h0); step();
        cdb(3'd2, 32'h22, 32'h0); step();
        chk("t2_wait", 32'(commit_valid), 32'd0);
        cdb(3'd1, 32'h11, 32'h0); step(); quiet();
        chk("t2_cv1", 32'(commit_valid), 32'd1);
        chk("t2_idx1", 32'(commit_idx), 32'd1);
        chk("t2_val1", commit_value, 32'h11);
        commit_ready = 1'b1; step();
        chk("t2_idx2", 32'(commit_idx), 32'd2);
        chk("t2_val2", commit_value, 32'h22);
        step();
        chk("t2_idx3", 32'(commit_idx), 32'd3);
        chk("t2_val3", commit_value, 32'h33);
        step(); commit_ready = 1'b0;
        chk("t2_cv_done", 32'(commit_valid), 32'd0);
        chk("t2_cnt", commit_count, 32'd4);
        chk("t2_head", 32'(commit_idx), 32'd4);

        // STORE held by commit_ready=0
        issue(3'd4, 3'd5, 5'd0); step();
        quiet(); cdb(3'd4, 32'hAB, 32'h100); step(); quiet();
        for (int k = 0; k < 3; k++) begin
            chk("st_cv", 32'(commit_valid), 32'd1);
            chk("st_op", 32'(commit_op), 32'd5);
            chk("st_val", commit_value, 32'hAB);
            chk("st_addr", commit_addr, 32'h100);
            step();
        end

        // issue into busy entry 4 plus CDB to free entry 6
        issue(3'd4, 3'd0, 5'd7); cdb(3'd6, 32'h77, 32'h7); step(); quiet();
        chk("err_pulse", 32'(issue_err), 32'd1);
        chk("err_busy", 32'(bv), 32'h10);
        chk("err_op", 32'(commit_op), 32'd5);
        chk("err_val", commit_value, 32'hAB);
        chk("err_cv", 32'(commit_valid), 32'd1);
        step();
        chk("err_clear", 32'(issue_err), 32'd0);
        // issue into the entry committing this cycle: rejected, commit proceeds
        issue(3'd4, 3'd0, 5'd7); commit_ready = 1'b1; step(); quiet(); commit_ready = 1'b0;
        chk("ic_err", 32'(issue_err), 32'd1);
        chk("ic_busy", 32'(bv), 32'h00);
        chk("ic_cnt", commit_count, 32'd5);
        chk("ic_head", 32'(commit_idx), 32'd5);

        // fill all eight starting at 5, writeback lagging one cycle
        for (int k = 0; k < 8; k++) begin
            e = 3'(5 + k);
            issue(e, 3'd0, 5'(k));
            if (k > 0) cdb(3'(e - 3'd1), 32'h40 + 32'(3'(e - 3'd1)), 32'h0);
            step();
        end
        quiet(); cdb(3'd4, 32'h44, 32'h0); step(); quiet();
        chk("full", 32'(rob_full), 32'd1);
        chk("full_busy", 32'(bv), 32'hFF);
        chk("full_cv", 32'(commit_valid), 32'd1);
        issue(3'd5, 3'd1, 5'd9); commit_ready = 1'b1; step(); quiet(); commit_ready = 1'b0;
        chk("free_busy", 32'(bv), 32'hDF);
        chk("free_full", 32'(rob_full), 32'd0);
        chk("free_err", 32'(issue_err), 32'd1);
        chk("free_cnt", commit_count, 32'd6);
        issue(3'd5, 3'd1, 5'd9); step(); quiet();
        chk("reissue_err", 32'(issue_err), 32'd0);
        chk("refull", 32'(rob_full), 32'd1);
        cdb(3'd5, 32'h99, 32'h0); step(); quiet();
        commit_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = 3'(6 + k);
            chk("wrap_cv", 32'(commit_valid), 32'd1);
            chk("wrap_idx", 32'(commit_idx), 32'(e));
            chk("wrap_val", commit_value, (e == 3'd5) ? 32'h99 : 32'h40 + 32'(e));
            step();
        end
        commit_ready = 1'b0;
        chk("wrap_empty", 32'(rob_empty), 32'd1);
        chk("wrap_cnt", commit_count, 32'd14);
        chk("wrap_head", 32'(commit_idx), 32'd6);

        // CDB to the entry being issued is ignored
        issue(3'd6, 3'd0, 5'd1); cdb(3'd6, 32'h55, 32'h0); step(); quiet();
        chk("cdb_on_issue", 32'(commit_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            issue(3'(7 + k), 3'd0, 5'd2); step();
        end
        quiet();
        chk("mid_busy", 32'(bv), 32'hC7);
        start = 1'b0; step(); start = 1'b1;
        chk("clr_busy", 32'(bv), 32'h00);
        chk("clr_empty", 32'(rob_empty), 32'd1);
        chk("clr_head", 32'(commit_idx), 32'd0);
        chk("clr_cnt", commit_count, 32'd0);
        chk("clr_cv", 32'(commit_valid), 32'd0);
        step();
        chk("clr_cv_after", 32'(commit_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
